// File: rtl/tone_gen.sv
// tone_gen: note/octave to square-wave tone generator with writable divider table.
// Preset-load counter advances on EN ticks; note changes land only at overflow.
module tone_gen #(
   parameter int CODE_W    = 11,
   parameter int IDX_W     = 4,
   parameter int NUM_NOTES = 16,
   parameter int OCT_W     = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic [IDX_W-1:0]  INX,
   input  logic [OCT_W-1:0]  OCT,
   input  logic              WR_EN,
   input  logic [IDX_W-1:0]  WR_ADDR,
   input  logic [CODE_W-1:0] WR_DATA,
   output logic              SPKS,
   output logic              OVF,
   output logic [CODE_W-1:0] CUR_CODE,
   output logic              RESTING
);

   localparam int AW = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
   localparam logic [CODE_W-1:0] ONES = '1;
   localparam logic [CODE_W:0]   FULL = {1'b1, {CODE_W{1'b0}}};
   localparam logic [CODE_W:0]   MIN_M = (CODE_W+1)'(2);
   localparam logic [0:0] ST_REST = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   function automatic logic [CODE_W-1:0] def_code(input int i);
      logic [11:0] v;
      case (i)
         0:  v = 12'h7FF;
         1:  v = 12'h305;
         2:  v = 12'h390;
         3:  v = 12'h40C;
         4:  v = 12'h45C;
         5:  v = 12'h4AD;
         6:  v = 12'h50A;
         7:  v = 12'h55C;
         8:  v = 12'h582;
         9:  v = 12'h5C8;
         10: v = 12'h606;
         11: v = 12'h640;
         12: v = 12'h656;
         13: v = 12'h684;
         14: v = 12'h69A;
         15: v = 12'h6C0;
         default: v = 12'hFFF;
      endcase
      if (i > 15) return ONES;
      return CODE_W'(v);
   endfunction

   logic [CODE_W-1:0] tbl [NUM_NOTES];
   logic              wr_ok;
   logic              rd_ok;
   logic [AW-1:0]     wr_idx;
   logic [AW-1:0]     rd_idx;
   logic [CODE_W-1:0] code;
   logic [CODE_W:0]   m;
   logic [CODE_W:0]   mk;
   logic [CODE_W:0]   sub;
   logic [CODE_W-1:0] preset_d;
   logic [CODE_W-1:0] preset_q;
   logic [CODE_W-1:0] cnt;
   logic [0:0]        state;

   assign wr_ok  = WR_EN && ({1'b0, WR_ADDR} < (IDX_W+1)'(NUM_NOTES));
   assign rd_ok  = {1'b0, INX} < (IDX_W+1)'(NUM_NOTES);
   assign wr_idx = AW'(WR_ADDR);
   assign rd_idx = AW'(INX);

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NUM_NOTES; i++) tbl[i] <= def_code(i);
      end else if (wr_ok) begin
         tbl[wr_idx] <= WR_DATA;
      end
   end

   // Shift the half-period length, not the code, so octaves are exact powers of two.
   always_comb begin
      code = rd_ok ? tbl[rd_idx] : ONES;
      m    = FULL - {1'b0, code};
      mk   = m >> OCT;
      if (mk < MIN_M) mk = MIN_M;
      sub      = FULL - mk;
      preset_d = (code == ONES) ? ONES : sub[CODE_W-1:0];
   end

   always_ff @(posedge CLK) begin
      if (RST) preset_q <= ONES;
      else     preset_q <= preset_d;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= ST_REST;
         cnt      <= ONES;
         CUR_CODE <= ONES;
         SPKS     <= 1'b0;
         OVF      <= 1'b0;
      end else begin
         OVF <= 1'b0;
         if (EN) begin
            case (state)
               ST_REST: begin
                  if (preset_q != ONES) begin
                     cnt      <= preset_q;
                     CUR_CODE <= preset_q;
                     state    <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (cnt != ONES) begin
                     cnt <= cnt + CODE_W'(1);
                  end else begin
                     OVF <= 1'b1;
                     if (preset_q == ONES) begin
                        state    <= ST_REST;
                        cnt      <= ONES;
                        CUR_CODE <= ONES;
                        SPKS     <= 1'b0;
                     end else begin
                        SPKS     <= ~SPKS;
                        cnt      <= preset_q;
                        CUR_CODE <= preset_q;
                     end
                  end
               end
               default: state <= ST_REST;
            endcase
         end
      end
   end

   assign RESTING = (state == ST_REST);

endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: vector table plus hand sequences; OVF intervals
// are checked against a queue of expected periods.
module tb_tone_gen;

   localparam int CW = 11;
   localparam int IW = 5;
   localparam int NN = 16;
   localparam int OW = 2;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          EN = 1'b0;
   logic [IW-1:0] INX = '0;
   logic [OW-1:0] OCT = '0;
   logic          WR_EN = 1'b0;
   logic [IW-1:0] WR_ADDR = '0;
   logic [CW-1:0] WR_DATA = '0;
   logic          SPKS;
   logic          OVF;
   logic [CW-1:0] CUR_CODE;
   logic          RESTING;

   tone_gen #(.CODE_W(CW), .IDX_W(IW), .NUM_NOTES(NN), .OCT_W(OW)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .INX(INX), .OCT(OCT),
      .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
      .SPKS(SPKS), .OVF(OVF), .CUR_CODE(CUR_CODE), .RESTING(RESTING)
   );

   always #5 CLK = ~CLK;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int ovf_cnt = 0;
   int last_ovf = 0;
   bit have_last = 0;
   bit spks_m = 0;
   bit sparse = 0;
   int ph = 0;
   int exp_q[$];

   typedef struct {
      logic [IW-1:0] inx;
      logic [OW-1:0] oct;
      logic [CW-1:0] code;
      int            period;
   } vec_t;

   vec_t vecs[7];

   task automatic check(string nm, int act, int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (OVF) begin
         ovf_cnt++;
         if (have_last && exp_q.size() > 0)
            check("ovf_interval", cyc - last_ovf, exp_q.pop_front());
         last_ovf  = cyc;
         have_last = 1;
         spks_m    = RESTING ? 1'b0 : ~spks_m;
         check("spks_on_ovf", int'(SPKS), int'(spks_m));
      end
      if (RST) begin
         have_last = 0;
         spks_m    = 0;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      ph++;
      if (sparse) EN = (ph % 4 == 0);
   endtask

   task automatic ticks(int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      sparse = 0;
      EN = 0;
      INX = '0;
      OCT = '0;
      WR_EN = 0;
      RST = 1;
      ticks(3);
      RST = 0;
   endtask

   task automatic wr(int addr, int data);
      WR_ADDR = IW'(addr);
      WR_DATA = CW'(data);
      WR_EN = 1;
      tick();
      WR_EN = 0;
   endtask

   task automatic wait_ovf(int bound);
      int n0;
      n0 = ovf_cnt;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (ovf_cnt != n0) break;
      end
      check("wait_ovf", int'(ovf_cnt != n0), 1);
   endtask

   task automatic push(int p, int n);
      repeat (n) exp_q.push_back(p);
   endtask

   task automatic drain(int bound);
      for (int i = 0; i < bound; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      check("sb_drain", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n0;
      vecs[0] = '{inx: 5'd1,  oct: 2'd0, code: 11'h305, period: 1275};
      vecs[1] = '{inx: 5'd1,  oct: 2'd1, code: 11'h583, period: 637};
      vecs[2] = '{inx: 5'd15, oct: 2'd3, code: 11'h7D8, period: 40};
      vecs[3] = '{inx: 5'd15, oct: 2'd0, code: 11'h6C0, period: 320};
      vecs[4] = '{inx: 5'd3,  oct: 2'd0, code: 11'h40C, period: 1012};
      vecs[5] = '{inx: 5'd8,  oct: 2'd2, code: 11'h761, period: 159};
      vecs[6] = '{inx: 5'd12, oct: 2'd0, code: 11'h656, period: 426};

      // reset defaults
      do_reset();
      check("rst_resting", int'(RESTING), 1);
      check("rst_spks", int'(SPKS), 0);
      check("rst_ovf", int'(OVF), 0);
      check("rst_cur_code", int'(CUR_CODE), 'h7FF);
      EN = 1;
      n0 = ovf_cnt;
      ticks(5000);
      check("idle_no_ovf", ovf_cnt - n0, 0);
      check("idle_resting", int'(RESTING), 1);
      check("idle_spks", int'(SPKS), 0);

      // note/octave vectors
      foreach (vecs[i]) begin
         do_reset();
         INX = vecs[i].inx;
         OCT = vecs[i].oct;
         EN = 1;
         wait_ovf(vecs[i].period + 20);
         push(vecs[i].period, 3);
         drain(vecs[i].period * 3 + 20);
         check("vec_cur_code", int'(CUR_CODE), int'(vecs[i].code));
         check("vec_running", int'(RESTING), 0);
      end

      // clamp at minimum half-period of 2
      do_reset();
      wr(5, 'h7FE);
      INX = 5;
      OCT = 3;
      EN = 1;
      wait_ovf(20);
      push(2, 4);
      drain(30);
      check("clamp_cur_code", int'(CUR_CODE), 'h7FE);

      // no EN, then immediate exit from rest and first overflow latency
      do_reset();
      INX = 1;
      n0 = ovf_cnt;
      ticks(50);
      check("noen_resting", int'(RESTING), 1);
      check("noen_no_ovf", ovf_cnt - n0, 0);
      EN = 1;
      tick();
      check("load_running", int'(RESTING), 0);
      check("load_cur_code", int'(CUR_CODE), 'h305);
      ticks(1274);
      check("first_ovf_early", int'(OVF), 0);
      tick();
      check("first_ovf", int'(OVF), 1);
      tick();
      check("ovf_one_clk", int'(OVF), 0);

      // glitch-free note change, then rest after next overflow
      do_reset();
      INX = 1;
      EN = 1;
      wait_ovf(1300);
      ticks(300);
      INX = 15;
      push(1275, 1);
      push(320, 2);
      drain(1275 + 700);
      INX = 0;
      push(320, 1);
      drain(400);
      check("stop_resting", int'(RESTING), 1);
      check("stop_spks", int'(SPKS), 0);
      n0 = ovf_cnt;
      ticks(3000);
      check("stop_no_ovf", ovf_cnt - n0, 0);

      // out-of-range writes and reads, table write, write collision
      do_reset();
      wr(20, 'h700);
      wr(16, 'h700);
      INX = 20;
      EN = 1;
      n0 = ovf_cnt;
      ticks(3000);
      check("oor_no_ovf", ovf_cnt - n0, 0);
      check("oor_resting", int'(RESTING), 1);
      INX = 4;
      wait_ovf(1000);
      push(932, 1);
      drain(1000);
      INX = 0;
      wait_ovf(1000);
      check("idx0_rest", int'(RESTING), 1);
      wr(3, 'h700);
      INX = 3;
      wait_ovf(300);
      push(256, 2);
      drain(600);
      check("wr_cur_code", int'(CUR_CODE), 'h700);
      ticks(100);
      wr(3, 'h780);
      push(256, 1);
      push(128, 2);
      drain(700);
      check("coll_cur_code", int'(CUR_CODE), 'h780);

      // sparse EN, then reset mid-period loses table writes
      do_reset();
      wr(3, 'h700);
      INX = 1;
      sparse = 1;
      wait_ovf(5200);
      push(5100, 2);
      drain(10400);
      ticks(1000);
      RST = 1;
      tick();
      check("mid_rst_spks", int'(SPKS), 0);
      check("mid_rst_ovf", int'(OVF), 0);
      check("mid_rst_resting", int'(RESTING), 1);
      check("mid_rst_cur_code", int'(CUR_CODE), 'h7FF);
      RST = 0;
      sparse = 0;
      INX = 3;
      EN = 1;
      wait_ovf(1100);
      push(1012, 1);
      drain(1100);
      check("lost_wr_cur_code", int'(CUR_CODE), 'h40C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
